// File: rtl/tile_xy_route_fifo.sv
// Purpose: one-dimension mesh hop buffer with two transit lanes, two delivery queues and local injection.
// Latency: one cycle from accepted push to FIFO head; no same-cycle bypass.
// Backpressure: lane_in_ready and inj_ready drop when the target FIFO is full; lane arrivals win over injection.

// Generic circular FIFO used for all four queues; head is first-word fall-through.
module tile_xy_route_fifo_q #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];
  assign full = (count == (AW+1)'(DEPTH));
endmodule

module tile_xy_route_fifo #(
  parameter int DATA_W     = 592,
  parameter int COORD_W    = 2,
  parameter int TILE_COORD = 0,
  parameter int DEPTH      = 8,
  parameter int AFULL      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inj_valid,
  output logic                  inj_ready,
  input  logic [DATA_W-1:0]     inj_data,
  input  logic [COORD_W-1:0]    inj_dst,
  input  logic [1:0]            lane_in_valid,
  output logic [1:0]            lane_in_ready,
  input  logic [2*DATA_W-1:0]   lane_in_data,
  input  logic [2*COORD_W-1:0]  lane_in_dst,
  output logic [1:0]            lane_out_valid,
  input  logic [1:0]            lane_out_ready,
  output logic [2*DATA_W-1:0]   lane_out_data,
  output logic [2*COORD_W-1:0]  lane_out_dst,
  output logic                  dlv_valid,
  input  logic                  dlv_ready,
  output logic [DATA_W-1:0]     dlv_data,
  output logic                  dlv_lane,
  output logic [1:0]            lane_afull,
  output logic                  err_misroute
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = COORD_W + DATA_W;
  localparam logic [COORD_W-1:0] HERE = COORD_W'(TILE_COORD);

  logic [1:0]        t_push, t_pop, t_full;
  logic [1:0]        d_push, d_pop, d_full, d_ne;
  logic [TW-1:0]     t_wdata [2];
  logic [TW-1:0]     t_head  [2];
  logic [CW-1:0]     t_cnt   [2];
  logic [DATA_W-1:0] d_wdata [2];
  logic [DATA_W-1:0] d_head  [2];
  logic [CW-1:0]     d_cnt   [2];

  logic [1:0] lane_acc, lane_to_t, lane_to_d, lane_drop;
  logic       inj_t0, inj_t1, inj_d1, inj_acc;
  logic       dsel, rr;

  // Lane arrival acceptance and routing: here -> delivery, onward -> transit, else drop.
  always_comb begin
    lane_in_ready = '0;
    lane_acc      = '0;
    lane_to_t     = '0;
    lane_to_d     = '0;
    lane_drop     = '0;
    for (int i = 0; i < 2; i++) begin
      lane_in_ready[i] = rst && !t_full[i] && !d_full[i];
      lane_acc[i]      = lane_in_valid[i] && lane_in_ready[i];
      lane_to_d[i]     = lane_acc[i] && (lane_in_dst[i*COORD_W +: COORD_W] == HERE);
      lane_to_t[i]     = lane_acc[i] && ((i == 1) ? (lane_in_dst[i*COORD_W +: COORD_W] > HERE)
                                                  : (lane_in_dst[i*COORD_W +: COORD_W] < HERE));
      lane_drop[i]     = lane_acc[i] && !lane_to_d[i] && !lane_to_t[i];
    end
  end

  // Injection target select and ready; yields to any lane push into the same queue.
  always_comb begin
    inj_t1 = (inj_dst > HERE);
    inj_t0 = (inj_dst < HERE);
    inj_d1 = !inj_t1 && !inj_t0;
    if (inj_t1)      inj_ready = rst && !t_full[1] && !lane_to_t[1];
    else if (inj_t0) inj_ready = rst && !t_full[0] && !lane_to_t[0];
    else             inj_ready = rst && !d_full[1] && !lane_to_d[1];
    inj_acc = inj_valid && inj_ready;
  end

  // Push muxing into the four queues.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      t_wdata[i] = lane_to_t[i] ? {lane_in_dst[i*COORD_W +: COORD_W], lane_in_data[i*DATA_W +: DATA_W]}
                                : {inj_dst, inj_data};
    end
    t_push[0]  = lane_to_t[0] || (inj_acc && inj_t0);
    t_push[1]  = lane_to_t[1] || (inj_acc && inj_t1);
    d_push[0]  = lane_to_d[0];
    d_push[1]  = lane_to_d[1] || (inj_acc && inj_d1);
    d_wdata[0] = lane_in_data[0 +: DATA_W];
    d_wdata[1] = lane_to_d[1] ? lane_in_data[DATA_W +: DATA_W] : inj_data;
  end

  // Transit outputs, almost-full flags and delivery arbitration.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lane_out_valid[i]                    = (t_cnt[i] != '0);
      t_pop[i]                             = lane_out_valid[i] && lane_out_ready[i];
      lane_out_data[i*DATA_W +: DATA_W]    = t_head[i][DATA_W-1:0];
      lane_out_dst[i*COORD_W +: COORD_W]   = t_head[i][TW-1 -: COORD_W];
      lane_afull[i]                        = rst && (t_cnt[i] >= CW'(AFULL));
      d_ne[i]                              = (d_cnt[i] != '0);
    end
    dsel      = (d_ne[0] && d_ne[1]) ? rr : d_ne[1];
    dlv_valid = |d_ne;
    dlv_lane  = dsel;
    dlv_data  = dsel ? d_head[1] : d_head[0];
    d_pop[0]  = dlv_valid && dlv_ready && !dsel;
    d_pop[1]  = dlv_valid && dlv_ready && dsel;
  end

  // Round-robin pointer moves past the favoured queue once it delivers; misroute is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr           <= 1'b0;
      err_misroute <= 1'b0;
    end else begin
      if (dlv_valid && dlv_ready && (dsel == rr)) rr <= ~rr;
      if (|lane_drop) err_misroute <= 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    tile_xy_route_fifo_q #(.W(TW), .DEPTH(DEPTH)) u_t (
      .clk(clk), .rst(rst), .push(t_push[g]), .wdata(t_wdata[g]), .pop(t_pop[g]),
      .head(t_head[g]), .count(t_cnt[g]), .full(t_full[g])
    );
    tile_xy_route_fifo_q #(.W(DATA_W), .DEPTH(DEPTH)) u_d (
      .clk(clk), .rst(rst), .push(d_push[g]), .wdata(d_wdata[g]), .pop(d_pop[g]),
      .head(d_head[g]), .count(d_cnt[g]), .full(d_full[g])
    );
  end
endmodule

// File: doc/tile_xy_route_fifo.md
Name: tile_xy_route_fifo

Overview:
- One-dimension mesh hop buffer for cache-line traffic between tiles.
- Two directional transit lanes: lane 0 carries decreasing coordinate, lane 1 increasing coordinate.
- Receives lane traffic from neighbours and forwards it, delivers traffic addressed to this tile, and injects local requests toward their destination.
- All queues use valid/ready flow control with real full/empty handling. One instance per dimension (X or Y) per tile.

Parameters:
- DATA_W, 592, payload width in bits (line data plus tag/size fields, opaque to this block).
- COORD_W, 2, width of the destination coordinate in this dimension.
- TILE_COORD, 0, this tile's coordinate in this dimension; range 0..2**COORD_W-1.
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- AFULL, 6, occupancy at which the lane_afull output asserts; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inj_valid  in  1  local injection request valid.
- inj_ready  out  1  injection accepted this cycle.
- inj_data  in  DATA_W  injection payload.
- inj_dst  in  COORD_W  injection destination coordinate.
- lane_in_valid  in  2  neighbour arrivals, index = lane.
- lane_in_ready  out  2  arrival accepted.
- lane_in_data  in  2xDATA_W  arrival payloads.
- lane_in_dst  in  2xCOORD_W  arrival destinations.
- lane_out_valid  out  2  transit FIFO head valid, toward the next neighbour.
- lane_out_ready  in  2  neighbour accepts the head.
- lane_out_data  out  2xDATA_W  transit head payloads.
- lane_out_dst  out  2xCOORD_W  transit head destinations.
- dlv_valid  out  1  local delivery valid.
- dlv_ready  in  1  local consumer accepts.
- dlv_data  out  DATA_W  delivered payload.
- dlv_lane  out  1  delivery FIFO the word came from.
- lane_afull  out  2  transit occupancy >= AFULL.
- err_misroute  out  1  sticky misroute flag.

Behaviour:
- Storage:
  - Four FIFOs of DEPTH entries: T0, T1 (transit) and D0, D1 (delivery).
  - Each has read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
  - Transit entries store {dst, data}.
- Reset (rst=0, asynchronous):
  - All pointers, counts, the round-robin pointer and err_misroute clear.
  - All valid outputs are 0; inj_ready, lane_in_ready and lane_afull are 0 while in reset.
  - Stored contents are discarded; reset mid-transfer drops the words in flight.
- Lane arrival routing, lane i:
  - dst == TILE_COORD: push Di.
  - Lane 1 with dst > TILE_COORD, or lane 0 with dst < TILE_COORD: push Ti.
  - Otherwise (misroute): accept and drop, set err_misroute. It stays set until reset.
- lane_in_ready[i] = !full(Ti) && !full(Di). It does not depend on lane_in_valid or on the arrival's dst.
- Injection routing:
  - dst > TILE_COORD: target T1.
  - dst < TILE_COORD: target T0.
  - dst == TILE_COORD: target D1 (loopback).
- Injection ready and priority:
  - inj_ready = target not full && no lane arrival pushing the same FIFO this cycle.
  - Lane arrivals have priority over injection.
  - inj_ready may depend on inj_dst but never on inj_valid.
- Transit output:
  - First-word fall-through: lane_out_valid[i] = count(Ti) != 0, and lane_out_data/dst show the head.
  - Pop when valid && ready.
- Delivery output:
  - Round-robin between D0 and D1; rr pointer resets to 0.
  - If only one is non-empty, that one is selected.
  - If both are non-empty, select Drr; rr flips to the other FIFO on each completed delivery handshake from Drr.
  - dlv_lane = index of the selected FIFO.
- Latency:
  - A word pushed at edge N is visible at the FIFO head after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
  - Minimum lane-in to lane-out latency is 1 cycle.
- Full and empty:
  - A push is only possible when not full; simultaneous push and pop at full is not possible, because ready is low.
  - Simultaneous push and pop at non-full, non-empty leaves the count unchanged.
  - Pop at empty cannot occur because valid is low.
- Count: incremented on push only, decremented on pop only. lane_afull[i] is combinational from count(Ti).
- Edge coordinates: TILE_COORD=0 makes any lane-0 arrival not addressed to this tile a misroute. Injection with dst < 0 is impossible, so T0 never receives injections.

Test Plan:
- Reset then idle (DEPTH=8, TILE_COORD=1): all valids 0, all counts 0, err_misroute 0; lane_in_ready=2'b11 and inj_ready=1 after rst rises.
- Lane 1 arrival dst=2, data=0xA5, at edge N: lane_out_valid[1]=1 with data 0xA5 in cycle N+1; dlv_valid stays 0.
- Fill T1 with 8 arrivals while lane_out_ready[1]=0: lane_afull[1] rises at the 6th; lane_in_ready[1]=0 after the 8th; a 9th valid arrival is not accepted. Drain one: ready returns the next cycle, and the FIFO order is preserved across pointer wrap.
- Lane 1 arrival dst=3 together with injection dst=2 in the same cycle: arrival accepted, inj_ready=0; injection accepted the following cycle; T1 order is arrival then injection.
- D0 and D1 each hold 3 words, dlv_ready=1 continuously: dlv_lane sequence 0,1,0,1,0,1.
- Lane 0 arrival dst=3 at TILE_COORD=1: accepted, dropped, err_misroute=1 and held until rst asserts; no FIFO count changes.
